// File: rtl/mdu_sequencer.sv
// Sequences MUL/MULTU/DIV/DIVU through the external multi-cycle multiplier/divider,
// stalls the issue stage while the unit works and writes HI/LO once per instruction.
module mdu_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_enable,
    input  logic        div_enable,
    input  logic        mul_signed,
    input  logic        div_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        mul_start,
    output logic        div_start,
    output logic        unit_signed,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        mul_done,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        stall,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MWAIT,
        DWAIT,
        WB
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mul_start_q;
    logic          div_start_q;
    logic          signed_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          we_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          tout_q;

    logic issue;
    logic time_up;

    assign issue   = (state_q == IDLE) && (mul_enable || div_enable) && !flush;
    assign time_up = (cnt_q == CW'(TIMEOUT - 1));

    // Stall must cover the issue cycle itself, so it cannot wait for the state register.
    assign stall = issue || (state_q == MWAIT) || (state_q == DWAIT);

    // Pulses (start, write strobe, timeout) default low and are raised only on the
    // transition that owns them, so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            signed_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            we_q        <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            tout_q      <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            we_q        <= 1'b0;
            tout_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        cnt_q <= '0;
                        if (mul_enable) begin
                            signed_q    <= mul_signed;
                            mul_start_q <= 1'b1;
                            state_q     <= MWAIT;
                        end else begin
                            signed_q <= div_signed;
                            // Divide-by-zero retires through WB without touching HI/LO.
                            if (op_b != 32'd0) begin
                                div_start_q <= 1'b1;
                                state_q     <= DWAIT;
                            end else begin
                                state_q <= WB;
                            end
                        end
                    end
                end
                MWAIT, DWAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (flush) begin
                        state_q <= IDLE;
                    end else if ((state_q == MWAIT) && mul_done) begin
                        hi_q    <= mul_hi;
                        lo_q    <= mul_lo;
                        we_q    <= 1'b1;
                        state_q <= WB;
                    end else if ((state_q == DWAIT) && div_done) begin
                        hi_q    <= div_rem;
                        lo_q    <= div_quot;
                        we_q    <= 1'b1;
                        state_q <= WB;
                    end else if (time_up) begin
                        tout_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_start   = mul_start_q;
    assign div_start   = div_start_q;
    assign unit_signed = signed_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign hi_we       = we_q;
    assign lo_we       = we_q;
    assign hi_wdata    = hi_q;
    assign lo_wdata    = lo_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: acts as the multiplier/divider and the HI/LO pair, and
// predicts every instruction's outcome from plain arithmetic and its timing rules.
module tb_mdu_sequencer;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_enable, div_enable, mul_signed, div_signed;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        mul_start, div_start, unit_signed;
    logic [31:0] unit_a, unit_b;
    logic        mul_done, div_done;
    logic [31:0] mul_hi, mul_lo, div_quot, div_rem;
    logic        stall, hi_we, lo_we, timeout_err;
    logic [31:0] hi_wdata, lo_wdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] hiReg = 32'h0;
    logic [31:0] loReg = 32'h0;
    logic [31:0] expHi = 32'h0;
    logic [31:0] expLo = 32'h0;

    mdu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mul_enable(mul_enable), .div_enable(div_enable),
        .mul_signed(mul_signed), .div_signed(div_signed),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .mul_start(mul_start), .div_start(div_start), .unit_signed(unit_signed),
        .unit_a(unit_a), .unit_b(unit_b),
        .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
        .stall(stall), .hi_we(hi_we), .lo_we(lo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quietInputs();
        mul_enable = 1'b0; div_enable = 1'b0; flush = 1'b0;
        mul_done = 1'b0;   div_done = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".stall"}, stall, 0);
        checkOutput({tag, ".we"}, {hi_we, lo_we}, 0);
        checkOutput({tag, ".start"}, {mul_start, div_start}, 0);
        checkOutput({tag, ".tout"}, timeout_err, 0);
    endtask

    // One instruction from issue to retirement. doneAt/flushAt are 1-based WAIT
    // cycle numbers (0 = never).
    task automatic applyStimulus(input bit isMul, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b, input int doneAt, input int flushAt,
                                 input bit lateDone);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        logic [31:0] rh, rl;
        bit divZero, expWrite, expTout;
        int endK, stallCnt, expStall;

        if (isMul) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sgn ? 64'(sa * sb) : ({32'h0, a} * {32'h0, b});
            rh = p[63:32];
            rl = p[31:0];
        end else if (b != 32'h0) begin
            rl = sgn ? 32'($signed(a) / $signed(b)) : a / b;
            rh = sgn ? 32'($signed(a) % $signed(b)) : a % b;
        end else begin
            rh = 32'h0;
            rl = 32'h0;
        end
        divZero  = !isMul && (b == 32'h0);
        expWrite = 1'b0;
        expTout  = 1'b0;
        endK     = 0;

        mul_enable = isMul; div_enable = !isMul;
        mul_signed = sgn;   div_signed = sgn;
        op_a = a; op_b = b;
        #1;
        checkOutput("issue.stall", stall, 1);
        stallCnt = 1;
        tick();
        mul_enable = 1'b0; div_enable = 1'b0;
        op_a = $urandom; op_b = $urandom;

        if (!divZero) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                mul_enable = 1'($urandom_range(1)); div_enable = 1'($urandom_range(1));
                flush = (k == flushAt);
                if (isMul) begin
                    mul_done = (k == doneAt);
                    mul_hi = mul_done ? rh : $urandom; mul_lo = mul_done ? rl : $urandom;
                    div_done = 1'($urandom_range(1)); div_quot = $urandom; div_rem = $urandom;
                end else begin
                    div_done = (k == doneAt);
                    div_rem = div_done ? rh : $urandom; div_quot = div_done ? rl : $urandom;
                    mul_done = 1'($urandom_range(1)); mul_hi = $urandom; mul_lo = $urandom;
                end
                #1;
                if (stall) stallCnt++;
                checkOutput("wait.startActive", isMul ? mul_start : div_start, (k == 1));
                checkOutput("wait.startOther", isMul ? div_start : mul_start, 0);
                checkOutput("wait.unitA", unit_a, a);
                checkOutput("wait.unitB", unit_b, b);
                checkOutput("wait.unitSigned", unit_signed, sgn);
                checkOutput("wait.we", {hi_we, lo_we}, 0);
                endK = k;
                if (k == flushAt) begin
                    tick(); break;
                end else if (k == doneAt) begin
                    expWrite = 1'b1; tick(); break;
                end else if (k == TIMEOUT) begin
                    expTout = 1'b1; tick(); break;
                end
                tick();
            end
        end

        quietInputs();
        if (divZero || expWrite) begin
            flush = 1'($urandom_range(1));
            mul_enable = 1'($urandom_range(1)); div_enable = 1'($urandom_range(1));
            #1;
            checkOutput("wb.stall", stall, 0);
            checkOutput("wb.hiWe", hi_we, expWrite);
            checkOutput("wb.loWe", lo_we, expWrite);
            checkOutput("wb.start", {mul_start, div_start}, 0);
            checkOutput("wb.tout", timeout_err, 0);
            if (expWrite) begin
                checkOutput("wb.hiData", hi_wdata, rh);
                checkOutput("wb.loData", lo_wdata, rl);
                expHi = rh; expLo = rl;
            end
            if (hi_we) hiReg = hi_wdata;
            if (lo_we) loReg = lo_wdata;
            tick();
            quietInputs();
        end else begin
            #1;
            checkOutput("end.tout", timeout_err, expTout);
            checkOutput("end.we", {hi_we, lo_we}, 0);
            checkOutput("end.stall", stall, 0);
            tick();
        end

        expStall = divZero ? 1 : 1 + endK;
        checkOutput("stallCycles", stallCnt, expStall);

        if (lateDone) begin
            for (int j = 0; j < 5; j++) begin
                mul_done = (j == 4); div_done = (j == 4);
                #1;
                checkQuiet("late");
                tick();
            end
            quietInputs();
        end
        #1;
        checkQuiet("idle");
        checkOutput("hiReg", hiReg, expHi);
        checkOutput("loReg", loReg, expLo);
        tick();
    endtask

    initial begin
        bit isMul, sgn;
        logic [31:0] a, b;
        int doneAt, flushAt;

        rst = 1'b1;
        quietInputs();
        mul_signed = 1'b0; div_signed = 1'b0; op_a = 32'h0; op_b = 32'h0;
        mul_hi = 32'h0; mul_lo = 32'h0; div_quot = 32'h0; div_rem = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checkQuiet("reset");
        checkOutput("reset.unitA", unit_a, 0);
        checkOutput("reset.hiData", hi_wdata, 0);
        tick();

        $display("[TB] directed MULTU");
        applyStimulus(1, 0, 32'hFFFF_FFFF, 32'd2, 3, 0, 0);
        $display("[TB] directed DIV -7/2");
        applyStimulus(0, 1, -32'sd7, 32'd2, 32, 0, 0);
        $display("[TB] directed DIVU by zero");
        applyStimulus(0, 0, 32'h1234_5678, 32'h0, 0, 0, 0);
        $display("[TB] directed flush in DWAIT with late done");
        applyStimulus(0, 1, 32'd100, 32'd7, 10, 5, 1);
        $display("[TB] directed flush and done together");
        applyStimulus(1, 1, 32'd9, 32'd9, 4, 4, 0);
        $display("[TB] directed watchdog timeout");
        applyStimulus(1, 0, 32'd5, 32'd6, 0, 0, 0);
        $display("[TB] directed back-to-back MULT then DIV");
        applyStimulus(1, 1, -32'sd3, 32'd1000, 2, 0, 0);
        applyStimulus(0, 0, 32'd1000, 32'd33, 1, 0, 0);

        $display("[TB] directed reset mid-MWAIT");
        mul_enable = 1'b1; mul_signed = 1'b1; op_a = 32'hABCD; op_b = 32'h1234;
        tick();
        mul_enable = 1'b0;
        tick();
        rst = 1'b1; mul_done = 1'b1; mul_hi = 32'hDEAD; mul_lo = 32'hBEEF;
        tick();
        rst = 1'b0; mul_done = 1'b0;
        #1;
        checkQuiet("rstMid");
        checkOutput("rstMid.unitA", unit_a, 0);
        checkOutput("rstMid.unitSigned", unit_signed, 0);
        checkOutput("rstMid.loData", lo_wdata, 0);
        tick();

        $display("[TB] random instructions");
        for (int n = 0; n < 40; n++) begin
            isMul = 1'($urandom_range(1));
            sgn   = 1'($urandom_range(1));
            a = $urandom;
            b = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
            if (isMul && b == 32'h0) b = 32'd17;
            if (!isMul && sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            doneAt  = $urandom_range(12, 1);
            flushAt = ($urandom_range(4) == 0) ? int'($urandom_range(12, 1)) : 0;
            applyStimulus(isMul, sgn, a, b, doneAt, flushAt, 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
